// File: rtl/keypad_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Key codes, scanner state encoding and row/column decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam logic [3:0] KEY_NONE   = 4'b1111;
    localparam logic [3:0] KEY_SET    = 4'b1110;
    localparam logic [3:0] KEY_CANCEL = 4'b1101;
    localparam logic [3:0] KEY_0      = 4'b1010;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        EMIT         = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } row_hit_t;

    // Exactly one active-low row gives a hit; none or several do not.
    function automatic row_hit_t row_decode(input logic [3:0] rows_n);
        row_hit_t r;
        r.hit = 1'b0;
        r.idx = 2'd0;
        case (rows_n)
            4'b1110: begin r.hit = 1'b1; r.idx = 2'd0; end
            4'b1101: begin r.hit = 1'b1; r.idx = 2'd1; end
            4'b1011: begin r.hit = 1'b1; r.idx = 2'd2; end
            4'b0111: begin r.hit = 1'b1; r.idx = 2'd3; end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = KEY_NONE;
        if (col != 2'd3) begin
            if (row == 2'd3) begin
                case (col)
                    2'd0:    code = KEY_CANCEL;
                    2'd1:    code = KEY_0;
                    default: code = KEY_SET;
                endcase
            end else begin
                code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
            end
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : keypad_sync
// Brief    : Two-flop synchroniser, asynchronously reset to all-ones (idle rows).
// Revision : 1.0 - initial release
// ============================================================================
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x3 matrix keypad scanner with debounce; one registered code per press.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    // The detecting sample is the first stable cycle, so DEBOUNCE adds DEBOUNCE_CYCLES-1 more.
    localparam logic [CW-1:0] PRESS_LAST = CW'(DEBOUNCE_CYCLES - 2);
    localparam logic [CW-1:0] REL_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    state_e          state_q, state_d;
    logic [1:0]      col_q, col_d;
    logic [1:0]      row_q, row_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;

    logic [3:0]      rows_s;
    logic [1:0]      col_next;
    logic [3:0]      row_pat;
    row_hit_t        hit;

    keypad_sync #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (row_n),
        .q_o   (rows_s)
    );

    assign col_next = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
    assign row_pat  = ~(4'b0001 << row_q);
    assign hit      = row_decode(rows_s);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        dwell_d     = dwell_q;
        cnt_d       = cnt_q;
        key_code_d  = KEY_NONE;
        key_valid_d = 1'b0;
        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (hit.hit) begin
                        row_d   = hit.idx;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            DEBOUNCE: begin
                if (rows_s == row_pat) begin
                    if (cnt_q == PRESS_LAST) begin
                        state_d = EMIT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = SCAN;
                    col_d   = col_next;
                    dwell_d = '0;
                end
            end
            EMIT: begin
                key_code_d  = key_lookup(row_q, col_q);
                key_valid_d = 1'b1;
                cnt_d       = '0;
                state_d     = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (rows_s == 4'b1111) begin
                    if (cnt_q == REL_LAST) begin
                        state_d = SCAN;
                        col_d   = col_next;
                        dwell_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            key_code_q  <= KEY_NONE;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col_n     = ~(3'b001 << col_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;

endmodule
`default_nettype wire
